rvfi_pc_trace_gen: RTL

- Synthetic RVFI retirement-stream source: the transmit end of the PC-continuity property that the PC forward/backward checkers receive.
- Drives `rvfi_valid`, `rvfi_order`, `rvfi_pc_rdata` and `rvfi_pc_wdata` across NRET channels. In a fault-free stream, each instruction's pc_rdata equals the pc_wdata of the instruction with order-1.
- Supports pseudo-random stalls, multi-retire and jumps, plus a single armed PC-corruption fault. Checker benches use it to prove both pass and fail paths.

---
 rtl/rvfi_gen_pkg.sv | 21 ++
 rtl/rvfi_gen_lfsr.sv | 25 ++
 rtl/rvfi_pc_trace_gen.sv | 115 +++++++++++
 3 files changed

// File: rtl/rvfi_gen_pkg.sv
// Shared constants, the per-channel retirement record and the LFSR step
// function used by the synthetic RVFI PC trace generator.
package rvfi_gen_pkg;

    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;
    localparam int unsigned PC_STEP      = 4;

    // PC fields are sized for the widest supported XLEN; narrower builds use the low bits.
    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [63:0] pc_rdata;
        logic [63:0] pc_wdata;
    } rvfi_rec_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] state);
        return state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
    endfunction

endpackage

// File: rtl/rvfi_gen_lfsr.sv
// 32-bit Galois LFSR that advances on request; an all-zero seed is replaced
// by 1 so the register can never lock up.
module rvfi_gen_lfsr
    import rvfi_gen_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        advance,
    output logic [31:0] state
);

    localparam logic [31:0] SEED_SAFE = (SEED == 32'h0) ? 32'h1 : SEED;

    always_ff @(posedge clock) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (reset) begin
            state <= SEED_SAFE;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/rvfi_pc_trace_gen.sv
// Synthetic RVFI retirement stream with stalls, multi-retire, jumps and a
// single armed pc_rdata corruption for exercising PC-continuity checkers.
module rvfi_pc_trace_gen
    import rvfi_gen_pkg::*;
#(
    parameter int               XLEN       = 32,
    parameter int               NRET       = 2,
    parameter logic [XLEN-1:0]  RESET_PC   = 'h1000,
    parameter logic [31:0]      SEED       = DEFAULT_SEED,
    parameter logic [XLEN-1:0]  FAULT_MASK = 'h4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 stall_en,
    input  logic                 jump_en,
    input  logic                 fault_arm,
    input  logic [63:0]          fault_order,
    output logic [NRET-1:0]      rvfi_valid,
    output logic [64*NRET-1:0]   rvfi_order,
    output logic [XLEN*NRET-1:0] rvfi_pc_rdata,
    output logic [XLEN*NRET-1:0] rvfi_pc_wdata,
    output logic [63:0]          retired_count,
    output logic                 fault_fired
);

    logic [31:0]     lfsr;
    logic [XLEN-1:0] lfsr_x;
    logic [63:0]     next_order;
    logic [XLEN-1:0] next_pc;
    logic            fault_armed;
    logic [63:0]     fault_order_q;

    logic [2:0]      k;
    logic [XLEN-1:0] pc_run;
    logic [XLEN-1:0] pc_nxt;
    logic            fire;
    rvfi_rec_t       rec [NRET];

    rvfi_gen_lfsr #(.SEED(SEED)) u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .advance (enable),
        .state   (lfsr)
    );

    assign lfsr_x = {(XLEN/32){lfsr}};
    assign k = (stall_en && lfsr[1:0] == 2'b00) ? 3'd0
                                                : 3'(32'(lfsr[4:2]) % NRET + 1);

    // Expand this cycle's k retirements onto the low channels, chaining the PC.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        pc_run = next_pc;
        pc_nxt = '0;
        fire   = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            rec[i] = '0;
            if (3'(i) < k) begin
                pc_nxt = (jump_en && lfsr[8+i]) ? {pc_run[XLEN-1:2] ^ lfsr_x[XLEN-1:2], 2'b00}
                                                : pc_run + XLEN'(PC_STEP);
                rec[i].valid    = 1'b1;
                rec[i].order    = next_order + 64'(i);
                rec[i].pc_rdata = 64'(pc_run);
                rec[i].pc_wdata = 64'(pc_nxt);
                // Only the reported pc_rdata is corrupted; the chain keeps the true PC.
                if (fault_armed && rec[i].order == fault_order_q) begin
                    rec[i].pc_rdata = 64'(pc_run ^ FAULT_MASK);
                    fire            = 1'b1;
                end
                pc_run = pc_nxt;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            next_order    <= '0;
            next_pc       <= RESET_PC;
            fault_armed   <= 1'b0;
            fault_order_q <= '0;
            rvfi_valid    <= '0;
            rvfi_order    <= '0;
            rvfi_pc_rdata <= '0;
            rvfi_pc_wdata <= '0;
            retired_count <= '0;
            fault_fired   <= 1'b0;
        end else begin
            // A new arm takes effect from the next cycle and overrides a same-cycle fire.
            if (fault_arm) begin
                fault_armed   <= 1'b1;
                fault_order_q <= fault_order;
            end else if (enable && fire) begin
                fault_armed <= 1'b0;
            end

            if (enable) begin
                next_order    <= next_order + 64'(k);
                next_pc       <= pc_run;
                retired_count <= retired_count + 64'(k);
                fault_fired   <= fire;
                for (int i = 0; i < NRET; i++) begin
                    rvfi_valid[i]                  <= rec[i].valid;
                    rvfi_order[64*i +: 64]         <= rec[i].order;
                    rvfi_pc_rdata[XLEN*i +: XLEN]  <= rec[i].pc_rdata[XLEN-1:0];
                    rvfi_pc_wdata[XLEN*i +: XLEN]  <= rec[i].pc_wdata[XLEN-1:0];
                end
            end else begin
                rvfi_valid  <= '0;
                fault_fired <= 1'b0;
            end
        end
    end

endmodule
